// File: rtl/beat_sequencer.sv
// Tempo/position sequencer: steps the song index once per beat and silences the
// melody player whenever the song is not actively playing.
module beat_sequencer #(
    parameter int BEAT_TICKS = 12500000,
    parameter int LAST_BEAT  = 158,
    parameter int SILENT_IDX = 255
) (
    input  logic       CLOCK_50,
    input  logic       rst_n,
    input  logic       start,
    input  logic       pause,
    input  logic       stop,
    input  logic       loop_en,
    input  logic [1:0] tempo_sel,
    output logic [7:0] beats,
    output logic       beat_strobe,
    output logic       playing,
    output logic       song_done
);

    localparam int TW = $clog2(BEAT_TICKS * 2);

    typedef enum logic [1:0] {IDLE, PLAY, PAUSED, DONE} state_t;

    state_t        state;
    logic [TW-1:0] tick;
    logic [TW-1:0] period_m1;
    logic [TW-1:0] next_period_m1;
    logic [7:0]    idx;
    logic [7:0]    idx_next;
    logic          boundary;
    logic          at_last;

    // The period is kept as period-1 so the halved/doubled value fits the tick width.
    always_comb begin
        next_period_m1 = TW'(BEAT_TICKS - 1);
        case (tempo_sel)
            2'b01:   next_period_m1 = TW'(BEAT_TICKS / 2 - 1);
            2'b10:   next_period_m1 = TW'(BEAT_TICKS * 2 - 1);
            default: next_period_m1 = TW'(BEAT_TICKS - 1);
        endcase
    end

    assign boundary = (tick == period_m1);
    assign at_last  = (idx == 8'(LAST_BEAT));
    assign idx_next = at_last ? 8'd0 : idx + 8'd1;

    always_ff @(posedge CLOCK_50) begin
        beat_strobe <= 1'b0;
        song_done   <= 1'b0;
        if (!rst_n) begin
            state     <= IDLE;
            idx       <= 8'd0;
            tick      <= '0;
            period_m1 <= TW'(BEAT_TICKS - 1);
            beats     <= 8'(SILENT_IDX);
            playing   <= 1'b0;
        end else if (stop) begin
            state   <= IDLE;
            idx     <= 8'd0;
            tick    <= '0;
            beats   <= 8'(SILENT_IDX);
            playing <= 1'b0;
        end else if (start) begin
            state       <= PLAY;
            idx         <= 8'd0;
            tick        <= '0;
            period_m1   <= next_period_m1;
            beats       <= 8'd0;
            beat_strobe <= 1'b1;
            playing     <= 1'b1;
        end else begin
            case (state)
                PLAY: begin
                    if (boundary && at_last && !loop_en) begin
                        state     <= DONE;
                        idx       <= 8'd0;
                        tick      <= '0;
                        beats     <= 8'(SILENT_IDX);
                        playing   <= 1'b0;
                        song_done <= 1'b1;
                    end else begin
                        if (boundary) begin
                            tick      <= '0;
                            period_m1 <= next_period_m1;
                            idx       <= idx_next;
                        end else begin
                            tick <= tick + TW'(1);
                        end
                        // The pause cycle still counts as played time, so resume keeps the remaining beat length.
                        if (pause) begin
                            state   <= PAUSED;
                            beats   <= 8'(SILENT_IDX);
                            playing <= 1'b0;
                        end else begin
                            beats       <= boundary ? idx_next : idx;
                            beat_strobe <= boundary;
                        end
                    end
                end
                PAUSED: begin
                    if (pause) begin
                        state   <= PLAY;
                        beats   <= idx;
                        playing <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_beat_sequencer.sv
// Directed bench for beat_sequencer with BEAT_TICKS=4; each task checks one scenario.
module tb_beat_sequencer;

    logic       CLOCK_50;
    logic       rst_n;
    logic       start;
    logic       pause;
    logic       stop;
    logic       loop_en;
    logic [1:0] tempo_sel;
    logic [7:0] beats;
    logic       beat_strobe;
    logic       playing;
    logic       song_done;

    int checks;
    int failures;

    beat_sequencer #(
        .BEAT_TICKS(4),
        .LAST_BEAT (158),
        .SILENT_IDX(255)
    ) dut (
        .CLOCK_50   (CLOCK_50),
        .rst_n      (rst_n),
        .start      (start),
        .pause      (pause),
        .stop       (stop),
        .loop_en    (loop_en),
        .tempo_sel  (tempo_sel),
        .beats      (beats),
        .beat_strobe(beat_strobe),
        .playing    (playing),
        .song_done  (song_done)
    );

    initial CLOCK_50 = 1'b0;
    always #5 CLOCK_50 = ~CLOCK_50;

    // Advance n clock edges and settle just after the last one.
    task automatic step(input int n);
        repeat (n) begin
            @(posedge CLOCK_50);
            #1;
        end
    endtask

    // Pulse start for one edge; afterwards the bench sits in cycle T+1.
    task automatic pulse_start();
        start = 1'b1;
        step(1);
        start = 1'b0;
    endtask

    task automatic pulse_stop();
        stop = 1'b1;
        step(1);
        stop = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        step(2);
        checks++;
        if (beats !== 8'd255 || playing !== 1'b0 || beat_strobe !== 1'b0 || song_done !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_state: beats=%0d playing=%b strobe=%b done=%b, expected 255 0 0 0",
                     beats, playing, beat_strobe, song_done);
        end
        rst_n = 1'b1;
        step(1);
    endtask

    task automatic test_full_song();
        loop_en = 1'b0;
        pulse_start();
        checks++;
        if (beats !== 8'd0 || beat_strobe !== 1'b1 || playing !== 1'b1) begin
            failures++;
            $display("[TB] FAIL song_first_beat: beats=%0d strobe=%b playing=%b, expected 0 1 1", beats, beat_strobe, playing);
        end
        step(1);
        checks++;
        if (beats !== 8'd0 || beat_strobe !== 1'b0) begin
            failures++;
            $display("[TB] FAIL song_strobe_width: beats=%0d strobe=%b, expected 0 0", beats, beat_strobe);
        end
        step(2);
        checks++;
        if (beats !== 8'd0) begin
            failures++;
            $display("[TB] FAIL song_beat0_len: beats=%0d at T+4, expected 0", beats);
        end
        step(1);
        checks++;
        if (beats !== 8'd1 || beat_strobe !== 1'b1) begin
            failures++;
            $display("[TB] FAIL song_beat1: beats=%0d strobe=%b at T+5, expected 1 1", beats, beat_strobe);
        end
        step(628);
        checks++;
        if (beats !== 8'd158 || beat_strobe !== 1'b1) begin
            failures++;
            $display("[TB] FAIL song_last_beat: beats=%0d strobe=%b at T+633, expected 158 1", beats, beat_strobe);
        end
        step(4);
        checks++;
        if (beats !== 8'd255 || song_done !== 1'b1 || playing !== 1'b0 || beat_strobe !== 1'b0) begin
            failures++;
            $display("[TB] FAIL song_done_pulse: beats=%0d done=%b playing=%b strobe=%b, expected 255 1 0 0",
                     beats, song_done, playing, beat_strobe);
        end
        step(1);
        checks++;
        if (song_done !== 1'b0 || beats !== 8'd255) begin
            failures++;
            $display("[TB] FAIL song_done_width: done=%b beats=%0d, expected 0 255", song_done, beats);
        end
    endtask

    task automatic test_loop();
        loop_en = 1'b1;
        pulse_start();
        step(636);
        checks++;
        if (beats !== 8'd0 || beat_strobe !== 1'b1 || song_done !== 1'b0 || playing !== 1'b1) begin
            failures++;
            $display("[TB] FAIL loop_wrap: beats=%0d strobe=%b done=%b playing=%b, expected 0 1 0 1",
                     beats, beat_strobe, song_done, playing);
        end
        pulse_stop();
        checks++;
        if (beats !== 8'd255 || playing !== 1'b0 || song_done !== 1'b0) begin
            failures++;
            $display("[TB] FAIL loop_stop: beats=%0d playing=%b done=%b, expected 255 0 0", beats, playing, song_done);
        end
        loop_en = 1'b0;
    endtask

    task automatic test_tempo();
        tempo_sel = 2'b01;
        pulse_start();
        step(1);
        checks++;
        if (beats !== 8'd0) begin
            failures++;
            $display("[TB] FAIL tempo_fast_beat0: beats=%0d at T+2, expected 0", beats);
        end
        step(1);
        checks++;
        if (beats !== 8'd1 || beat_strobe !== 1'b1) begin
            failures++;
            $display("[TB] FAIL tempo_fast_beat1: beats=%0d strobe=%b at T+3, expected 1 1", beats, beat_strobe);
        end
        tempo_sel = 2'b10;
        step(2);
        checks++;
        if (beats !== 8'd2 || beat_strobe !== 1'b1) begin
            failures++;
            $display("[TB] FAIL tempo_switch_boundary: beats=%0d strobe=%b at T+5, expected 2 1", beats, beat_strobe);
        end
        step(7);
        checks++;
        if (beats !== 8'd2) begin
            failures++;
            $display("[TB] FAIL tempo_slow_hold: beats=%0d at T+12, expected 2", beats);
        end
        step(1);
        checks++;
        if (beats !== 8'd3 || beat_strobe !== 1'b1) begin
            failures++;
            $display("[TB] FAIL tempo_slow_beat3: beats=%0d strobe=%b at T+13, expected 3 1", beats, beat_strobe);
        end
        tempo_sel = 2'b00;
        pulse_stop();
    endtask

    task automatic test_pause_resume();
        pulse_start();
        step(5);
        checks++;
        if (beats !== 8'd1) begin
            failures++;
            $display("[TB] FAIL pause_pre: beats=%0d at T+6, expected 1", beats);
        end
        pause = 1'b1;
        step(1);
        pause = 1'b0;
        checks++;
        if (beats !== 8'd255 || playing !== 1'b0 || beat_strobe !== 1'b0) begin
            failures++;
            $display("[TB] FAIL pause_enter: beats=%0d playing=%b strobe=%b at T+7, expected 255 0 0",
                     beats, playing, beat_strobe);
        end
        tempo_sel = 2'b01;
        step(19);
        checks++;
        if (beats !== 8'd255) begin
            failures++;
            $display("[TB] FAIL pause_hold: beats=%0d at T+26, expected 255", beats);
        end
        tempo_sel = 2'b00;
        pause = 1'b1;
        step(1);
        pause = 1'b0;
        checks++;
        if (beats !== 8'd1 || beat_strobe !== 1'b0 || playing !== 1'b1) begin
            failures++;
            $display("[TB] FAIL pause_resume: beats=%0d strobe=%b playing=%b at T+27, expected 1 0 1",
                     beats, beat_strobe, playing);
        end
        step(1);
        checks++;
        if (beats !== 8'd1) begin
            failures++;
            $display("[TB] FAIL pause_remaining: beats=%0d at T+28, expected 1", beats);
        end
        step(1);
        checks++;
        if (beats !== 8'd2 || beat_strobe !== 1'b1) begin
            failures++;
            $display("[TB] FAIL pause_next_beat: beats=%0d strobe=%b at T+29, expected 2 1", beats, beat_strobe);
        end
        // Period 4 proves the tempo change made while paused was not latched.
        step(3);
        checks++;
        if (beats !== 8'd2) begin
            failures++;
            $display("[TB] FAIL pause_tempo_unlatched: beats=%0d at T+32, expected 2", beats);
        end
        pulse_stop();
    endtask

    task automatic test_commands();
        pulse_start();
        step(1);
        start = 1'b1;
        stop  = 1'b1;
        step(1);
        start = 1'b0;
        stop  = 1'b0;
        checks++;
        if (beats !== 8'd255 || playing !== 1'b0 || beat_strobe !== 1'b0) begin
            failures++;
            $display("[TB] FAIL cmd_stop_over_start: beats=%0d playing=%b strobe=%b, expected 255 0 0",
                     beats, playing, beat_strobe);
        end
        start = 1'b1;
        pause = 1'b1;
        step(1);
        start = 1'b0;
        pause = 1'b0;
        checks++;
        if (beats !== 8'd0 || beat_strobe !== 1'b1 || playing !== 1'b1) begin
            failures++;
            $display("[TB] FAIL cmd_start_over_pause: beats=%0d strobe=%b playing=%b, expected 0 1 1",
                     beats, beat_strobe, playing);
        end
        pulse_stop();
        pause = 1'b1;
        step(1);
        pause = 1'b0;
        step(2);
        checks++;
        if (beats !== 8'd255 || playing !== 1'b0 || beat_strobe !== 1'b0) begin
            failures++;
            $display("[TB] FAIL cmd_pause_idle: beats=%0d playing=%b strobe=%b, expected 255 0 0",
                     beats, playing, beat_strobe);
        end
        pulse_start();
        step(636);
        checks++;
        if (song_done !== 1'b1 || beats !== 8'd255) begin
            failures++;
            $display("[TB] FAIL cmd_reach_done: done=%b beats=%0d, expected 1 255", song_done, beats);
        end
        pause = 1'b1;
        step(1);
        pause = 1'b0;
        step(3);
        checks++;
        if (beats !== 8'd255 || playing !== 1'b0 || beat_strobe !== 1'b0 || song_done !== 1'b0) begin
            failures++;
            $display("[TB] FAIL cmd_pause_done: beats=%0d playing=%b strobe=%b done=%b, expected 255 0 0 0",
                     beats, playing, beat_strobe, song_done);
        end
        pulse_start();
        checks++;
        if (beats !== 8'd0 || beat_strobe !== 1'b1 || playing !== 1'b1) begin
            failures++;
            $display("[TB] FAIL cmd_restart_done: beats=%0d strobe=%b playing=%b, expected 0 1 1",
                     beats, beat_strobe, playing);
        end
        pulse_stop();
    endtask

    task automatic test_reset_mid_song();
        pulse_start();
        step(200);
        checks++;
        if (beats !== 8'd50) begin
            failures++;
            $display("[TB] FAIL midreset_pre: beats=%0d at T+201, expected 50", beats);
        end
        rst_n = 1'b0;
        step(1);
        rst_n = 1'b1;
        checks++;
        if (beats !== 8'd255 || playing !== 1'b0 || beat_strobe !== 1'b0 || song_done !== 1'b0) begin
            failures++;
            $display("[TB] FAIL midreset_state: beats=%0d playing=%b strobe=%b done=%b, expected 255 0 0 0",
                     beats, playing, beat_strobe, song_done);
        end
        step(2);
        checks++;
        if (beats !== 8'd255 || playing !== 1'b0) begin
            failures++;
            $display("[TB] FAIL midreset_stays_idle: beats=%0d playing=%b, expected 255 0", beats, playing);
        end
        pulse_start();
        checks++;
        if (beats !== 8'd0 || beat_strobe !== 1'b1) begin
            failures++;
            $display("[TB] FAIL midreset_restart: beats=%0d strobe=%b, expected 0 1", beats, beat_strobe);
        end
        step(3);
        checks++;
        if (beats !== 8'd0) begin
            failures++;
            $display("[TB] FAIL midreset_full_beat: beats=%0d at T+4, expected 0", beats);
        end
        step(1);
        checks++;
        if (beats !== 8'd1 || beat_strobe !== 1'b1) begin
            failures++;
            $display("[TB] FAIL midreset_beat1: beats=%0d strobe=%b at T+5, expected 1 1", beats, beat_strobe);
        end
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        rst_n     = 1'b0;
        start     = 1'b0;
        pause     = 1'b0;
        stop      = 1'b0;
        loop_en   = 1'b0;
        tempo_sel = 2'b00;
        test_reset();
        test_full_song();
        test_loop();
        test_tempo();
        test_pause_resume();
        test_commands();
        test_reset_mid_song();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/beat_sequencer.md
Name: beat_sequencer

Overview:
- Upstream tempo/position sequencer for the melody player.
- Generates the 8-bit `beats` song-position index that the melody player decodes into a note tone.
- Provides start, pause, stop, loop and tempo control.
- Drives the silence index (8'd255, outside the song table) whenever not playing, so the player outputs 0.

Parameters:
- BEAT_TICKS, 12500000, CLOCK_50 cycles per beat at normal tempo (0.25 s); must be an even value ≥ 2.
- LAST_BEAT, 158, final in-song index; song spans 0..LAST_BEAT.
- SILENT_IDX, 255, index driven when not playing; must be > LAST_BEAT.

Ports:
- CLOCK_50  input  1  system clock, 50 MHz.
- rst_n  input  1  synchronous active-low reset.
- start  input  1  1-cycle pulse: begin or restart the song at beat 0.
- pause  input  1  1-cycle pulse: toggle PLAY/PAUSE.
- stop  input  1  1-cycle pulse: abort to IDLE.
- loop_en  input  1  level: wrap to beat 0 after LAST_BEAT instead of finishing.
- tempo_sel  input  2  00 normal, 01 double speed, 10 half speed, 11 normal.
- beats  output  8  registered song index to the melody player.
- beat_strobe  output  1  1-cycle pulse each time `beats` takes a new in-song value.
- playing  output  1  high in PLAY.
- song_done  output  1  1-cycle pulse on natural end of song.

Behaviour:
- Sync reset (rst_n=0 at a CLOCK_50 edge) has priority over everything, including mid-beat.
  - state=IDLE, idx=0, tick=0, period=BEAT_TICKS.
  - beats=SILENT_IDX, beat_strobe=0, playing=0, song_done=0.
- All outputs are registered. `beats` = idx in PLAY, otherwise SILENT_IDX.
- Period is computed from tempo_sel:
  - 00/11 → BEAT_TICKS.
  - 01 → BEAT_TICKS/2.
  - 10 → BEAT_TICKS*2.
  - tick counter is wide enough for BEAT_TICKS*2−1.
- Period is latched only on entry to beat 0 and at each beat boundary. A tempo_sel change mid-beat takes effect on the next beat.
- Command priority within one cycle: stop > start > pause. Lower-priority commands in that cycle are ignored.
- States:
  - IDLE: start → PLAY with idx=0, tick=0, period latched; beats=0 and beat_strobe=1 on the next cycle. pause ignored.
  - PLAY:
    - tick increments each cycle.
    - At tick==period−1: tick←0 and period re-latched.
    - If idx<LAST_BEAT: idx+1, beat_strobe pulse.
    - If idx==LAST_BEAT and loop_en=1: idx←0, beat_strobe pulse, no song_done.
    - If idx==LAST_BEAT and loop_en=0: → DONE, beats=SILENT_IDX, song_done=1 for one cycle, playing=0.
    - loop_en is sampled at the boundary cycle only.
    - start → restart at beat 0 exactly as from IDLE.
    - pause → PAUSE; tick and idx held; beats=SILENT_IDX next cycle.
  - PAUSE:
    - pause or start → PLAY.
      - pause resumes with the held idx and tick. beats=idx next cycle, no beat_strobe. The remaining beat time equals the time left at the pause.
      - start restarts at beat 0 with beat_strobe.
    - tempo_sel changes during PAUSE are not latched.
  - DONE: holds beats=SILENT_IDX. start → PLAY from beat 0. pause ignored.
- stop in any state → IDLE next cycle: beats=SILENT_IDX, tick=0, idx=0, playing=0, no song_done.
- beat_strobe and song_done are never high in the same cycle.
- Every beat lasts exactly its latched period in PLAY cycles. The first beat after start lasts period cycles counted from the cycle beats becomes 0.

Test Plan:
All tests use BEAT_TICKS=4 and LAST_BEAT=158.
1. Reset then start, loop_en=0, tempo_sel=00:
   - start pulse at cycle T.
   - beats=0 with strobe at T+1; beats=1 at T+5; beats=158 at T+633.
   - beats=255, song_done=1, playing=0 at T+637; song_done=0 at T+638.
2. Same as 1 with loop_en=1: at T+637 beats=0 with beat_strobe=1, song_done stays 0, playing stays 1.
3. Tempo:
   - tempo_sel=01 from start: beats increments every 2 cycles.
   - Switch to 10 at T+3 (mid beat 1): beat 1 still ends at T+5 (period 2); beats=2 at T+5 lasts 8 cycles → beats=3 at T+13.
4. Pause/resume:
   - pause at T+6 (beat 1, tick=1): beats=255 from T+7.
   - Hold 20 cycles, pause again at T+26: beats=1 at T+27, no strobe; beats=2 at T+29.
5. Simultaneous and ignored commands:
   - start+stop in the same PLAY cycle → IDLE, beats=255.
   - start+pause in IDLE → PLAY at beat 0.
   - pause in IDLE or DONE → no change.
6. Reset mid-operation: rst_n=0 for 1 cycle at beat 50 → next cycle beats=255, playing=0, no strobe/done. A later start begins at beat 0 with a full 4-cycle beat.
